// File: rtl/ntt_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ntt_sched: Kyber NTT layer/butterfly sequencer; NTT_SCHED_INTT_EN adds INTT |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ntt_sched #(
  parameter int BF_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       inverse_i,
  input  logic       stall_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] layer_o,
  output logic       bf_valid_o,
  output logic [7:0] bf_addr_a_o,
  output logic [7:0] bf_addr_b_o,
  output logic [6:0] bf_zeta_idx_o,
  output logic       bf_inv_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;
  localparam logic [3:0] C_LAT_M1 = 4'(BF_LATENCY - 1);

  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] layer_q, layer_d;
  logic [3:0] drain_q, drain_d;
  logic       inv_mode;
  logic       issue;
  logic [7:0] len, addr_a, addr_b;
  logic [6:0] grp, zeta;

`ifdef NTT_SCHED_INTT_EN
  logic inv_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inv_q <= 1'b0;
    end else if (state_q == C_IDLE && start_i) begin
      inv_q <= inverse_i;
    end
  end
  assign inv_mode = inv_q;
`else
  logic unused_inverse;
  assign unused_inverse = inverse_i;
  assign inv_mode       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    drain_d = drain_q;
    case (state_q)
      C_IDLE: begin
        if (start_i) begin
          state_d = C_ISSUE;
          cnt_d   = '0;
          layer_d = '0;
        end
      end
      C_ISSUE: begin
        if (!stall_i) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'd127) begin
            state_d = C_DRAIN;
            drain_d = '0;
          end
        end
      end
      C_DRAIN: begin
        // Hold off the next layer until every write of this one has landed.
        if (drain_q == C_LAT_M1) begin
          drain_d = '0;
          if (layer_q == 3'd6) begin
            state_d = C_DONE;
          end else begin
            state_d = C_ISSUE;
            layer_d = layer_q + 3'd1;
          end
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      C_DONE: begin
        state_d = C_IDLE;
        layer_d = '0;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      layer_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
    end
  end

  // Group index selects the block, low bits of the counter the offset inside it.
  always_comb begin
    len    = 8'd128 >> layer_q;
    grp    = cnt_q >> (3'd7 - layer_q);
    addr_a = ({1'b0, grp} << (4'd8 - {1'b0, layer_q})) | ({1'b0, cnt_q} & (len - 8'd1));
    zeta   = (7'd1 << layer_q) + grp;
`ifdef NTT_SCHED_INTT_EN
    if (inv_mode) begin
      len    = 8'd2 << layer_q;
      grp    = cnt_q >> (layer_q + 3'd1);
      addr_a = ({1'b0, grp} << ({1'b0, layer_q} + 4'd2)) | ({1'b0, cnt_q} & (len - 8'd1));
      zeta   = (7'd127 >> layer_q) - grp;
    end
`endif
    addr_b = addr_a + len;
  end

  assign issue         = (state_q == C_ISSUE) && !stall_i;
  assign bf_valid_o    = issue;
  assign bf_addr_a_o   = issue ? addr_a : 8'd0;
  assign bf_addr_b_o   = issue ? addr_b : 8'd0;
  assign bf_zeta_idx_o = issue ? zeta : 7'd0;
  assign bf_inv_o      = inv_mode;
  assign busy_o        = (state_q == C_ISSUE) || (state_q == C_DRAIN);
  assign done_o        = (state_q == C_DONE);
  assign layer_o       = layer_q;

  // Free-running write-back delay line: {valid, a, b}.
  logic [16:0] dly_q [BF_LATENCY];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= {issue, bf_addr_a_o, bf_addr_b_o};
      for (int i = 1; i < BF_LATENCY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign wr_en_o     = dly_q[BF_LATENCY-1][16];
  assign wr_addr_a_o = dly_q[BF_LATENCY-1][15:8];
  assign wr_addr_b_o = dly_q[BF_LATENCY-1][7:0];

endmodule
`default_nettype wire

// File: tb/tb_ntt_sched.sv
`default_nettype none
// tb_ntt_sched: scoreboard bench for ntt_sched (main instance L=4, sweep instances L=1 and L=15).
module tb_ntt_sched;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset, start, inverse, stall, start_sw;
  always #5 clk = ~clk;

  logic       busy, done, bf_valid, bf_inv, wr_en;
  logic [2:0] layer;
  logic [7:0] bf_a, bf_b, wr_a, wr_b;
  logic [6:0] bf_z;

  ntt_sched #(.BF_LATENCY(L)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .inverse_i(inverse), .stall_i(stall),
    .busy_o(busy), .done_o(done), .layer_o(layer), .bf_valid_o(bf_valid),
    .bf_addr_a_o(bf_a), .bf_addr_b_o(bf_b), .bf_zeta_idx_o(bf_z), .bf_inv_o(bf_inv),
    .wr_en_o(wr_en), .wr_addr_a_o(wr_a), .wr_addr_b_o(wr_b)
  );

  logic       sw_busy [2], sw_done [2], sw_valid [2], sw_inv [2], sw_we [2];
  logic [2:0] sw_layer [2];
  logic [7:0] sw_a [2], sw_b [2], sw_wa [2], sw_wb [2];
  logic [6:0] sw_z [2];

  ntt_sched #(.BF_LATENCY(1)) dut_l1 (
    .clk_i(clk), .reset_i(reset), .start_i(start_sw), .inverse_i(1'b0), .stall_i(1'b0),
    .busy_o(sw_busy[0]), .done_o(sw_done[0]), .layer_o(sw_layer[0]), .bf_valid_o(sw_valid[0]),
    .bf_addr_a_o(sw_a[0]), .bf_addr_b_o(sw_b[0]), .bf_zeta_idx_o(sw_z[0]), .bf_inv_o(sw_inv[0]),
    .wr_en_o(sw_we[0]), .wr_addr_a_o(sw_wa[0]), .wr_addr_b_o(sw_wb[0])
  );

  ntt_sched #(.BF_LATENCY(15)) dut_l15 (
    .clk_i(clk), .reset_i(reset), .start_i(start_sw), .inverse_i(1'b0), .stall_i(1'b0),
    .busy_o(sw_busy[1]), .done_o(sw_done[1]), .layer_o(sw_layer[1]), .bf_valid_o(sw_valid[1]),
    .bf_addr_a_o(sw_a[1]), .bf_addr_b_o(sw_b[1]), .bf_zeta_idx_o(sw_z[1]), .bf_inv_o(sw_inv[1]),
    .wr_en_o(sw_we[1]), .wr_addr_a_o(sw_wa[1]), .wr_addr_b_o(sw_wb[1])
  );

  typedef struct {
    int cyc; int lay; int c; int a; int b; int z; int inv;
  } bf_t;

  bf_t iq[$];
  bf_t wq[$];
  int  cyc = 0, base = 0, total = 0, bad = 0, done_exp = 0, n_issue = 0;
  bit  chk_en = 1'b0, done_seen = 1'b0;
  bit  [255:0] cov;
  bit  stall_map [2048];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference butterfly: plain block/offset arithmetic.
  function automatic bf_t model(input int l, input int c, input bit inv);
    bf_t e;
    int  len, g;
    if (inv) begin
      len = 2 << l;
      g   = c / len;
      e.z = 2 * (64 >> l) - 1 - g;
    end else begin
      len = 128 >> l;
      g   = c / len;
      e.z = (1 << l) + g;
    end
    e.a   = g * 2 * len + c % len;
    e.b   = e.a + len;
    e.lay = l;
    e.c   = c;
    e.inv = inv;
    e.cyc = 0;
    return e;
  endfunction

  // mode 0: no stall, 1: 10 stalled cycles in layer 2, 2: random bursts + random stall in drain.
  task automatic plan(input bit inv, input int mode);
    int  k [7];
    int  n [7];
    int  ls;
    bf_t e;
    foreach (stall_map[i]) stall_map[i] = 1'b0;
    iq.delete();
    wq.delete();
    ls = 1;
    for (int l = 0; l < 7; l++) begin
      k[l] = 0;
      n[l] = 0;
      if (mode == 1 && l == 2) begin k[l] = 50; n[l] = 10; end
      if (mode == 2) begin
        k[l] = (l == 3) ? 127 : $urandom_range(0, 127);
        n[l] = (l == 3) ? $urandom_range(1, 12) : $urandom_range(0, 12);
      end
      for (int c = 0; c < 128; c++) begin
        e     = model(l, c, inv);
        e.cyc = ls + c + ((c >= k[l]) ? n[l] : 0);
        iq.push_back(e);
        wq.push_back(e);
      end
      for (int s = 0; s < n[l]; s++) stall_map[ls + k[l] + s] = 1'b1;
      if (mode == 2)
        for (int d = 0; d < L; d++) stall_map[ls + 128 + n[l] + d] = 1'($urandom_range(0, 1));
      ls += 128 + L + n[l];
    end
    done_exp = ls;
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, {busy, done, layer, bf_valid, bf_a, bf_b, bf_z, bf_inv, wr_en, wr_a, wr_b}, 0);
  endtask

  task automatic run(input bit inv, input int mode, input int mid_start, input int abort_at);
    int  r, lim;
    bit  eff;
`ifdef NTT_SCHED_INTT_EN
    eff = inv;
`else
    eff = 1'b0;
`endif
    plan(eff, mode);
    n_issue   = 0;
    done_seen = 1'b0;
    cov       = '0;
    @(posedge clk); #1;
    start   = 1'b1;
    inverse = inv;
    base    = cyc + 1;
    chk_en  = 1'b1;
    lim     = done_exp + 3;
    for (int i = 0; i < lim + 5; i++) begin
      @(posedge clk); #1;
      r       = cyc - base + 1;
      start   = (r == mid_start);
      inverse = 1'($urandom_range(0, 1));
      stall   = (r < 2048) ? stall_map[r] : 1'b0;
      if (abort_at != 0 && r == abort_at) begin
        reset  = 1'b1;
        chk_en = 1'b0;
        iq.delete();
        wq.delete();
        @(negedge clk);
        check_all_zero("outputs after mid-run reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        start = 1'b0;
        repeat (30) @(posedge clk);
        return;
      end
      if (r >= lim) break;
    end
    stall = 1'b0;
    start = 1'b0;
    chk("done seen", done_seen, 1);
    chk("issue count", n_issue, 896);
    chk("issue queue drained", iq.size(), 0);
    chk("write queue drained", wq.size(), 0);
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    int  rel;
    bf_t e;
    rel = cyc - base + 1;
    if (!chk_en) begin
      if (bf_valid || wr_en) chk("spurious strobe while idle", 1, 0);
    end else begin
      if (bf_valid) begin
        if (iq.size() == 0) begin
          chk("unexpected issue", 1, 0);
        end else begin
          e = iq.pop_front();
          n_issue++;
          chk("issue cycle", rel, e.cyc);
          chk("addr a", bf_a, e.a);
          chk("addr b", bf_b, e.b);
          chk("zeta idx", bf_z, e.z);
          chk("layer", layer, e.lay);
          chk("bf_inv", bf_inv, e.inv);
          chk("busy at issue", busy, 1);
          cov[bf_a] = 1'b1;
          cov[bf_b] = 1'b1;
          if (e.c == 127) begin
            chk("layer address coverage", $countones(cov), 256);
            cov = '0;
          end
        end
      end
      if (wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected write", 1, 0);
        end else begin
          e = wq.pop_front();
          chk("write cycle", rel, e.cyc + L);
          chk("write addr a", wr_a, e.a);
          chk("write addr b", wr_b, e.b);
        end
      end
      if (done) begin
        chk("done cycle", rel, done_exp);
        chk("busy at done", busy, 0);
        done_seen = 1'b1;
      end
    end
  end

  task automatic reset_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("outputs after idle reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic sweep();
    int d1, d15, v1, v15, r, b;
    d1 = -1; d15 = -1; v1 = 0; v15 = 0;
    @(posedge clk); #1;
    start_sw = 1'b1;
    @(posedge clk); #1;
    start_sw = 1'b0;
    b = cyc;
    for (int i = 0; i < 1010; i++) begin
      @(negedge clk);
      r = cyc - b + 1;
      if (sw_valid[0]) v1++;
      if (sw_valid[1]) v15++;
      if (sw_done[0]) d1 = r;
      if (sw_done[1]) d15 = r;
    end
    chk("L=1 done cycle", d1, 1 + 7 * (128 + 1));
    chk("L=15 done cycle", d15, 1 + 7 * (128 + 15));
    chk("L=1 issue count", v1, 896);
    chk("L=15 issue count", v15, 896);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    inverse  = 1'b0;
    stall    = 1'b0;
    start_sw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset state");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    run(1'b0, 0, 300, 0);
    reset_idle();
    run(1'b0, 1, 0, 0);
    run(1'b0, 2, 500, 0);
    run(1'b1, 0, 0, 0);
    run(1'b1, 2, 0, 0);
    run(1'b0, 0, 0, 200);
    run(1'b0, 0, 0, 0);
    sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
